// File: rtl/run_length_detector.sv
// Serial run detector: counts consecutive MATCH_BIT samples and flags runs of at least
// the effective threshold once they are terminated by the opposite bit.
module run_length_detector #(
  parameter int unsigned CNT_W     = 8,
  parameter bit          MATCH_BIT = 1'b1,
  parameter int unsigned DEF_THR   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             c,
  input  logic [CNT_W-1:0] thr,
  input  logic             clr_hits,
  output logic             d,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] hits,
  output logic             active
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    QUAL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] run_len_nx, hits_nx;
  logic [CNT_W-1:0] thr_eff, cnt_inc;
  logic             d_nx, match;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      d       <= 1'b0;
      run_len <= '0;
      hits    <= '0;
      active  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      d       <= d_nx;
      run_len <= run_len_nx;
      hits    <= hits_nx;
      active  <= (state_nx == QUAL);
    end
  end

  // Next state; threshold is re-evaluated on every enabled sample
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    d_nx       = 1'b0;
    run_len_nx = run_len;
    hits_nx    = hits;
    thr_eff    = (thr == '0) ? CNT_W'(DEF_THR) : thr;
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    match      = (c == MATCH_BIT);

    if (en) begin
      unique case (state)
        IDLE: begin
          if (match) begin
            cnt_nx   = CNT_ONE;
            state_nx = (thr_eff <= CNT_ONE) ? QUAL : COUNT;
          end
        end
        COUNT: begin
          if (match) begin
            cnt_nx   = cnt_inc;
            state_nx = (cnt_inc >= thr_eff) ? QUAL : COUNT;
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
        QUAL: begin
          if (match) begin
            cnt_nx   = cnt_inc;
            state_nx = (cnt_inc >= thr_eff) ? QUAL : COUNT;
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
            // A raised threshold can disqualify the run at its terminating sample
            if (cnt >= thr_eff) begin
              d_nx       = 1'b1;
              run_len_nx = cnt;
              hits_nx    = (hits == CNT_MAX) ? hits : hits + CNT_ONE;
            end
          end
        end
        default: begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      endcase
    end

    if (clr_hits) hits_nx = d_nx ? CNT_ONE : '0;
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Randomised scoreboard bench for run_length_detector (CNT_W=4 so saturation is reachable).
module tb_run_length_detector;

  localparam int unsigned W    = 4;
  localparam int          MAXV = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1, en = 1'b0, c = 1'b0, clr_hits = 1'b0;
  logic [W-1:0] thr = '0;
  logic         d, active;
  logic [W-1:0] run_len, hits;

  run_length_detector #(.CNT_W(W), .MATCH_BIT(1'b1), .DEF_THR(2)) dut (
    .clk(clk), .reset(reset), .en(en), .c(c), .thr(thr), .clr_hits(clr_hits),
    .d(d), .run_len(run_len), .hits(hits), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit d;
    int run_len;
    int hits;
    bit active;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;

  // Reference model: true run length plus "reached threshold" flag
  int m_run = 0;
  bit m_qual = 1'b0;
  int m_runlen = 0;
  int m_hits = 0;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
  endtask

  task automatic drive(input bit r, input bit e, input bit cc, input int t, input bit clr);
    int   teff;
    bit   det;
    exp_t x;
    @(negedge clk);
    reset = r; en = e; c = cc; thr = W'(t); clr_hits = clr;
    teff = (t == 0) ? 2 : t;
    det  = 1'b0;
    if (r) begin
      m_run = 0; m_qual = 1'b0; m_runlen = 0; m_hits = 0;
    end else begin
      if (e) begin
        if (cc) begin
          m_run++;
          m_qual = (sat(m_run) >= teff);
        end else begin
          if (m_qual && sat(m_run) >= teff) begin
            det      = 1'b1;
            m_runlen = sat(m_run);
            m_hits   = sat(m_hits + 1);
          end
          m_run  = 0;
          m_qual = 1'b0;
        end
      end
      if (clr) m_hits = det ? 1 : 0;
    end
    x.d = det; x.run_len = m_runlen; x.hits = m_hits; x.active = m_qual;
    q.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle, compare against the oldest expectation
  always @(posedge clk) begin
    exp_t x;
    #1;
    cycle++;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("d", int'(d), int'(x.d));
      chk("run_len", int'(run_len), x.run_len);
      chk("hits", int'(hits), x.hits);
      chk("active", int'(active), int'(x.active));
    end
  end

  task automatic ones(input int n, input int t);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, t, 1'b0);
  endtask

  initial begin
    int t;
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    // Default threshold: 1,1,0
    ones(2, 0); drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    // thr=3: short run ignored, run of 4 detected
    ones(2, 3); drive(1'b0, 1'b1, 1'b0, 3, 1'b0);
    ones(4, 3); drive(1'b0, 1'b1, 1'b0, 3, 1'b0);
    // en=0 blocks the zero
    drive(1'b0, 1'b1, 1'b1, 2, 1'b0); drive(1'b0, 1'b0, 1'b0, 2, 1'b0); ones(1, 2);
    drive(1'b0, 1'b1, 1'b0, 2, 1'b0);
    // Long run saturates run_len
    ones(20, 2); drive(1'b0, 1'b1, 1'b0, 2, 1'b0);
    // Drive hits into saturation, then clear together with a detection
    for (int i = 0; i < 16; i++) begin ones(2, 1); drive(1'b0, 1'b1, 1'b0, 1, 1'b0); end
    ones(2, 2); drive(1'b0, 1'b1, 1'b0, 2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 2, 1'b1);
    // Threshold raised mid-run disqualifies, lowered qualifies on next one
    ones(3, 2); drive(1'b0, 1'b1, 1'b0, 5, 1'b0);
    ones(2, 5); ones(1, 2); drive(1'b0, 1'b1, 1'b0, 2, 1'b0);
    // Reset while active mid-run
    ones(3, 2); drive(1'b1, 1'b1, 1'b1, 2, 1'b0); drive(1'b0, 1'b1, 1'b0, 2, 1'b0);
    // Random traffic
    t = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) t = $urandom_range(5);
      drive(($urandom_range(499) == 0), ($urandom_range(99) < 85),
            ($urandom_range(99) < 65), t, ($urandom_range(99) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
